execute_stage: RTL and testbench

- Y86-64 pipeline execute stage. Consumes the E pipeline register produced by decode_up (E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat).
- Computes the ALU result, updates the condition-code register and evaluates branch and cmov conditions.
- Clocks results into the M pipeline register. Drives the forwarding taps e_valE and e_dstE, which feed back into decode_up.

---
 rtl/execute_stage.sv | 156 +++++++++++++++
 tb/tb_execute_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes,
// branch/cmov condition evaluation and the M pipeline register.
module execute_stage #(
  parameter int          DATA_W   = 64,
  parameter logic [3:0]  REG_NONE = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [1:0]        E_stat,
  input  logic [1:0]        m_stat,
  input  logic [1:0]        W_stat,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_Cnd,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic [1:0]        M_stat,
  output logic [2:0]        cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [DATA_W-1:0] EIGHT     = DATA_W'(8);
  localparam logic [DATA_W-1:0] NEG_EIGHT = '0 - EIGHT;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fn;
  logic              new_zf;
  logic              new_sf;
  logic              new_of;
  logic              set_cc;
  logic              zf;
  logic              sf;
  logic              of;

  // Operand selection by instruction class
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = NEG_EIGHT;
      I_RET, I_POPQ:               alu_a = EIGHT;
      default:                     alu_a = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // ALU and the flags it would produce; only OPq honours ifun
  always_comb begin
    alu_fn = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;
    e_valE = '0;
    new_of = 1'b0;
    case (alu_fn)
      ALU_ADD: begin
        e_valE = alu_b + alu_a;
        new_of = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                 (e_valE[DATA_W-1] != alu_a[DATA_W-1]);
      end
      ALU_SUB: begin
        e_valE = alu_b - alu_a;
        new_of = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                 (e_valE[DATA_W-1] != alu_b[DATA_W-1]);
      end
      ALU_AND: e_valE = alu_b & alu_a;
      ALU_XOR: e_valE = alu_b ^ alu_a;
      default: e_valE = '0;
    endcase
    new_zf = (e_valE == '0);
    new_sf = e_valE[DATA_W-1];
  end

  // An exception already in M or W freezes the flags
  assign set_cc = (E_icode == I_OPQ) && (m_stat == 2'd0) && (W_stat == 2'd0);

  // Condition-code register {ZF,SF,OF}
  always_ff @(posedge clk) begin
    if (reset)       cc <= 3'b100;
    else if (set_cc) cc <= {new_zf, new_sf, new_of};
  end

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  // Branch / cmov condition from the registered flags
  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = (sf ^ of) | zf;
      4'h2:    e_Cnd = sf ^ of;
      4'h3:    e_Cnd = zf;
      4'h4:    e_Cnd = ~zf;
      4'h5:    e_Cnd = ~(sf ^ of);
      4'h6:    e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  // A cmov that is not taken writes nothing
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_dstE;

  // M pipeline register; reset and bubble both insert a nop
  always_ff @(posedge clk) begin
    if (reset || M_bubble) begin
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
      M_stat  <= 2'd0;
    end else begin
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
      M_stat  <= E_stat;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [1:0]  E_stat, m_stat, W_stat;
  logic        M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd;
  logic [1:0]  M_stat;
  logic [2:0]  cc;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [2:0]  cc_m;
  logic [3:0]  mi_m, mde_m, mdm_m;
  logic        mc_m;
  logic [63:0] mve_m, mva_m;
  logic [1:0]  ms_m;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_a(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] vc);
    if (ic == 2 || ic == 6)             return va;
    if (ic >= 3 && ic <= 5)             return vc;
    if (ic == 8 || ic == 10)            return 64'hFFFF_FFFF_FFFF_FFF8;
    if (ic == 9 || ic == 11)            return 64'd8;
    return 64'd0;
  endfunction

  function automatic logic [63:0] ref_b(input logic [3:0] ic, input logic [63:0] vb);
    if (ic >= 4 && ic <= 11 && ic != 7) return vb;
    return 64'd0;
  endfunction

  // result, and flags {ZF,SF,OF} via 65-bit signed overflow detection
  function automatic logic [66:0] ref_alu(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [3:0] op;
    logic [63:0] r;
    logic signed [64:0] wa, wb, wide;
    logic ovf;
    op  = (ic == 6) ? fn : 4'd0;
    wa  = {a[63], a};
    wb  = {b[63], b};
    ovf = 1'b0;
    case (op)
      0: begin wide = wb + wa; r = wide[63:0]; ovf = (wide != {r[63], r}); end
      1: begin wide = wb - wa; r = wide[63:0]; ovf = (wide != {r[63], r}); end
      2: r = a & b;
      3: r = a ^ b;
      default: r = 64'd0;
    endcase
    return {(r == 64'd0), r[63], ovf, r};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] f);
    logic z, s, o, less;
    z = f[2]; s = f[1]; o = f[0];
    less = s ^ o;
    case (fn)
      0: return 1'b1;
      1: return less || z;
      2: return less;
      3: return z;
      4: return !z;
      5: return !less;
      6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_e(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                       input logic [3:0] dm, input logic [1:0] st);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm; E_stat = st;
  endtask

  // check forward taps, clock one edge, update model, check M and cc
  task automatic cycle();
    logic [66:0] res;
    logic        cnd;
    logic [3:0]  dste;
    #1;
    res  = ref_alu(E_icode, E_ifun, ref_a(E_icode, E_valA, E_valC), ref_b(E_icode, E_valB));
    cnd  = ref_cnd(E_ifun, cc_m);
    dste = (E_icode == 2 && !cnd) ? 4'hF : E_dstE;
    check("e_valE", e_valE, res[63:0]);
    check("e_Cnd", {63'd0, e_Cnd}, {63'd0, cnd});
    check("e_dstE", {60'd0, e_dstE}, {60'd0, dste});
    @(posedge clk);
    if (reset) begin
      cc_m = 3'b100;
    end else if (E_icode == 6 && m_stat == 0 && W_stat == 0) begin
      cc_m = res[66:64];
    end
    if (reset || M_bubble) begin
      mi_m = 1; mc_m = 0; mve_m = 0; mva_m = 0; mde_m = 4'hF; mdm_m = 4'hF; ms_m = 0;
    end else begin
      mi_m = E_icode; mc_m = cnd; mve_m = res[63:0]; mva_m = E_valA;
      mde_m = dste; mdm_m = E_dstM; ms_m = E_stat;
    end
    #1;
    check("cc", {61'd0, cc}, {61'd0, cc_m});
    check("M_icode", {60'd0, M_icode}, {60'd0, mi_m});
    check("M_Cnd", {63'd0, M_Cnd}, {63'd0, mc_m});
    check("M_valE", M_valE, mve_m);
    check("M_valA", M_valA, mva_m);
    check("M_dstE", {60'd0, M_dstE}, {60'd0, mde_m});
    check("M_dstM", {60'd0, M_dstM}, {60'd0, mdm_m});
    check("M_stat", {62'd0, M_stat}, {62'd0, ms_m});
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    cc_m = 3'b100;
    mi_m = 1; mc_m = 0; mve_m = 0; mva_m = 0; mde_m = 4'hF; mdm_m = 4'hF; ms_m = 0;
    m_stat = 0; W_stat = 0; M_bubble = 0; reset = 1;
    set_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 2'd0);
    @(posedge clk);
    cycle();
    cycle();
    check("rst_M_icode", {60'd0, M_icode}, 64'd1);
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_M_dstE", {60'd0, M_dstE}, 64'hF);
    check("rst_M_valE", M_valE, 64'd0);
    reset = 0;

    // add overflow into sign bit
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF, 2'd0);
    #1 check("add_valE", e_valE, 64'h8000_0000_0000_0000);
    cycle();
    check("add_cc", {61'd0, cc}, 64'd3);

    // sub to zero, then cmovle taken, cmovl not taken
    set_e(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 2'd0);
    cycle();
    check("sub_cc", {61'd0, cc}, 64'd4);
    set_e(4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 2'd0);
    #1 check("cmovle_cnd", {63'd0, e_Cnd}, 64'd1);
    check("cmovle_dstE", {60'd0, e_dstE}, 64'd3);
    cycle();
    set_e(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 2'd0);
    #1 check("cmovl_cnd", {63'd0, e_Cnd}, 64'd0);
    check("cmovl_dstE", {60'd0, e_dstE}, 64'hF);
    cycle();
    check("cmovl_M_dstE", {60'd0, M_dstE}, 64'hF);

    // jne with ZF=1, then jmp
    set_e(4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 2'd0);
    cycle();
    check("jne_M_Cnd", {63'd0, M_Cnd}, 64'd0);
    set_e(4'h7, 4'h0, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 2'd0);
    cycle();
    check("jmp_M_Cnd", {63'd0, M_Cnd}, 64'd1);

    // stack pointer arithmetic leaves cc alone
    set_e(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4, 4'hF, 2'd0);
    #1 check("push_valE", e_valE, 64'hF8);
    cycle();
    set_e(4'hB, 4'h0, 64'h55, 64'hF8, 64'd0, 4'h4, 4'h5, 2'd0);
    #1 check("pop_valE", e_valE, 64'h100);
    cycle();
    check("pushpop_cc", {61'd0, cc}, 64'd4);

    // xor with memory exception pending: cc frozen
    m_stat = 2;
    set_e(4'h6, 4'h3, 64'd1, 64'd2, 64'd0, 4'h6, 4'hF, 2'd0);
    cycle();
    check("xor_mstat_cc", {61'd0, cc}, 64'd4);
    m_stat = 0;
    M_bubble = 1;
    cycle();
    check("bubble_M_icode", {60'd0, M_icode}, 64'd1);
    check("bubble_M_dstE", {60'd0, M_dstE}, 64'hF);
    check("bubble_cc", {61'd0, cc}, 64'd0);
    reset = 1;
    cycle();
    check("rstbub_cc", {61'd0, cc}, 64'd4);
    check("rstbub_M_icode", {60'd0, M_icode}, 64'd1);
    reset = 0;
    M_bubble = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_e(($urandom_range(0, 9) < 4) ? 4'h6 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
            rand64(), rand64(), rand64(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      m_stat   = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat   = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      M_bubble = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
